// File: rtl/sb_xbar_pkg.sv
// Shared definitions for the sb_xbar system bus crossbar: access size codes,
// FSM state encoding and the data returned on a decode error.
package sb_xbar_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [31:0] decerr_rdata(input logic en);
    return en ? DECERR_DATA : 32'h0;
  endfunction

endpackage

// File: rtl/sb_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i in ascending wrap-around order, as one-hot and encoded index.
module sb_rr_arb #(
  parameter int NM = 2,
  parameter int IW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [NM-1:0] gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [NM-1:0] rot;
  logic [IW:0]   pos;
  logic          found;

  // rot[i] is the request of master (ptr_i + i) mod NM
  assign rot = NM'({req_i, req_i} >> ptr_i);

  always_comb begin
    found = 1'b0;
    pos   = '0;
    idx_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = {1'b0, ptr_i} + (IW+1)'(i);
        if (pos >= (IW+1)'(NM)) pos = pos - (IW+1)'(NM);
        idx_o = pos[IW-1:0];
      end
    end
  end

  assign gnt_o = found ? (NM'(1) << idx_o) : '0;

endmodule

// File: rtl/sb_xbar.sv
// NM-master / NS-slave shared-path system bus with round-robin arbitration,
// lane steering and load extension. Define SB_DECERR_EN to flag unmapped slaves.
module sb_xbar
  import sb_xbar_pkg::*;
#(
  parameter int NM      = 2,
  parameter int NS      = 2,
  parameter int SEL_LSB = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_re,
  input  logic [NM-1:0]     m_we,
  input  logic [2*NM-1:0]   m_size,
  input  logic [NM-1:0]     m_un_sign,
  input  logic [32*NM-1:0]  m_addr,
  input  logic [32*NM-1:0]  m_wdata,
  output logic [32*NM-1:0]  m_rdata_o,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  input  logic [32*NS-1:0]  s_rdata,
  output logic [4*NS-1:0]   s_rw_o,
  output logic [31:0]       s_addr_o,
  output logic [31:0]       s_wdata_o
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
`ifdef SB_DECERR_EN
  localparam logic DECERR_ON = 1'b1;
`else
  localparam logic DECERR_ON = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, rr_inc, gidx_q, arb_idx;
  logic [NM-1:0] req, arb_gnt, ack_q, ack_d, gsel;
  logic [31:0]   addr_q, wdata_q, rdata_q, rdata_d;
  logic [1:0]    size_q;
  logic          uns_q, wr_q, err_q, err_d;
  logic [SW-1:0] sel_q;
  logic          misal, unmap;
  logic [31:0]   c_addr, c_wdata, rsel;
  logic [1:0]    c_size;
  logic          c_uns, c_wr;

  function automatic logic [3:0] st_we(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: return 4'b0001 << a;
      SZ_HALF: return 4'b0011 << {a[1], 1'b0};
      SZ_WORD: return 4'b1111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_lanes(input logic [31:0] wd, input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return {4{wd[7:0]}};
      SZ_HALF: return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign req = m_re | m_we;

  sb_rr_arb #(.NM(NM), .IW(IW)) u_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    c_addr  = '0;
    c_wdata = '0;
    c_size  = '0;
    c_uns   = 1'b0;
    c_wr    = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (arb_gnt[k]) begin
        c_addr  = m_addr[32*k +: 32];
        c_wdata = m_wdata[32*k +: 32];
        c_size  = m_size[2*k +: 2];
        c_uns   = m_un_sign[k];
        c_wr    = m_we[k];
      end
    end
  end

  always_comb begin
    rsel = '0;
    for (int k = 0; k < NS; k++) begin
      if (sel_q == SW'(k)) rsel = s_rdata[32*k +: 32];
    end
  end

  assign misal  = ((size_q == SZ_HALF) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
  assign unmap  = ({1'b0, sel_q} >= (SW+1)'(NS));
  assign gsel   = NM'(1) << gidx_q;
  assign rr_inc = (gidx_q == IW'(NM-1)) ? '0 : gidx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
    end
  end

  // Transaction latches and response data; only observed while qualified by state/ack.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && |req) begin
      gidx_q  <= arb_idx;
      addr_q  <= c_addr;
      wdata_q <= c_wdata;
      size_q  <= c_size;
      uns_q   <= c_uns;
      wr_q    <= c_wr;
      sel_q   <= c_addr[SEL_LSB +: SW];
    end
    rdata_q <= rdata_d;
    err_q   <= err_d;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE:  if (|req) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (misal || unmap || wr_q) begin
          state_d = ST_IDLE;
          rr_d    = rr_inc;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        rr_d    = rr_inc;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d     = '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    s_rw_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (state_q == ST_ISSUE) begin
      s_addr_o  = {2'b00, addr_q[31:2]};
      s_wdata_o = st_lanes(wdata_q, size_q);
      if (misal) begin
        ack_d = gsel;
        err_d = 1'b1;
      end else if (unmap) begin
        ack_d   = gsel;
        err_d   = DECERR_ON;
        rdata_d = decerr_rdata(DECERR_ON);
      end else if (wr_q) begin
        ack_d = gsel;
        for (int k = 0; k < NS; k++) begin
          if (sel_q == SW'(k)) s_rw_o[4*k +: 4] = st_we(size_q, addr_q[1:0]);
        end
      end
    end else if (state_q == ST_RESP) begin
      ack_d   = gsel;
      rdata_d = ld_extend(rsel, size_q, addr_q[1:0], uns_q);
    end
  end

  assign m_ack_o = ack_q;
  assign m_err_o = ack_q & {NM{err_q}};

  always_comb begin
    m_rdata_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (ack_q[k]) m_rdata_o[32*k +: 32] = rdata_q;
    end
  end

endmodule

// File: tb/tb_sb_xbar.sv
// Scoreboard bench for sb_xbar (NM=2, NS=3) with a BRAM-style slave model.
module tb_sb_xbar;

  localparam int NM = 2;
  localparam int NS = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    m_re = '0, m_we = '0, m_un_sign = '0;
  logic [2*NM-1:0]  m_size = '0;
  logic [32*NM-1:0] m_addr = '0, m_wdata = '0;
  logic [32*NM-1:0] m_rdata_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [32*NS-1:0] s_rdata;
  logic [4*NS-1:0]  s_rw_o;
  logic [31:0]      s_addr_o, s_wdata_o;

  always #5 clk = ~clk;

  sb_xbar #(.NM(NM), .NS(NS), .SEL_LSB(28)) dut (
    .clk(clk), .rst(rst), .m_re(m_re), .m_we(m_we), .m_size(m_size),
    .m_un_sign(m_un_sign), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata_o(m_rdata_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_rdata(s_rdata), .s_rw_o(s_rw_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o)
  );

  // Slave memories: 16 words each, registered read.
  logic [31:0] mem [NS][16];
  logic [31:0] srd [NS];
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      for (int b = 0; b < 4; b++)
        if (s_rw_o[4*k+b]) mem[k][s_addr_o[3:0]][8*b +: 8] <= s_wdata_o[8*b +: 8];
      srd[k] <= mem[k][s_addr_o[3:0]];
    end
  end
  assign s_rdata = {srd[2], srd[1], srd[0]};

  typedef struct { int m; logic err; logic [31:0] rd; } ack_t;
  typedef struct { logic [4*NS-1:0] rw; logic [31:0] a; logic [31:0] d; } wr_t;
  ack_t aq[$];
  wr_t  wq[$];
  ack_t ae;
  wr_t  we_;
  int errors = 0;
  int checks = 0;

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  // Ack monitor
  always @(negedge clk) begin
    if (m_ack_o != '0) begin
      checks++;
      if ($countones(m_ack_o) != 1) begin
        errors++;
        $display("FAIL ack_onehot got=%b want one-hot", m_ack_o);
      end
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack got=%b want none", m_ack_o);
      end else begin
        ae = aq.pop_front();
        checks++;
        if (!m_ack_o[ae.m]) begin
          errors++;
          $display("FAIL ack_master got=%b want bit %0d", m_ack_o, ae.m);
        end
        checks++;
        if (m_err_o[ae.m] !== ae.err) begin
          errors++;
          $display("FAIL ack_err m%0d got=%b want=%b", ae.m, m_err_o[ae.m], ae.err);
        end
        chk32("ack_rdata", m_rdata_o[32*ae.m +: 32], ae.rd);
        chk32("other_rdata", m_rdata_o[32*(1-ae.m) +: 32], 32'h0);
      end
    end
  end

  // Slave write monitor
  always @(negedge clk) begin
    if (s_rw_o != '0) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got rw=%h addr=%h", s_rw_o, s_addr_o);
      end else begin
        we_ = wq.pop_front();
        chk32("wr_rw", 32'(s_rw_o), 32'(we_.rw));
        chk32("wr_addr", s_addr_o, we_.a);
        chk32("wr_data", s_wdata_o, we_.d);
      end
    end
  end

  task automatic wexp(input logic [4*NS-1:0] rw, input logic [31:0] a, input logic [31:0] d);
    wq.push_back(wr_t'{rw, a, d});
  endtask

  task automatic txn(input int m, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] wd, input int lat,
                     input bit eerr, input logic [31:0] erd);
    int n;
    bit got;
    aq.push_back(ack_t'{m, eerr, erd});
    @(posedge clk); #1;
    m_re[m] = !wr;
    m_we[m] = wr;
    m_size[2*m +: 2] = sz;
    m_un_sign[m] = uns;
    m_addr[32*m +: 32] = a;
    m_wdata[32*m +: 32] = wd;
    got = 1'b0;
    n = 0;
    while (!got && n < 12) begin
      @(negedge clk);
      if (m_ack_o[m]) got = 1'b1;
      else n++;
    end
    m_re[m] = 1'b0;
    m_we[m] = 1'b0;
    checks++;
    if (!got || n != lat) begin
      errors++;
      $display("FAIL latency m%0d addr=%h got=%0d want=%0d", m, a, got ? n : -1, lat);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk32({nm, "_ack"}, 32'(m_ack_o), 32'h0);
    chk32({nm, "_err"}, 32'(m_err_o), 32'h0);
    chk32({nm, "_rw"}, 32'(s_rw_o), 32'h0);
    chk32({nm, "_saddr"}, s_addr_o, 32'h0);
    chk32({nm, "_swdata"}, s_wdata_o, 32'h0);
    chk32({nm, "_rdata0"}, m_rdata_o[31:0], 32'h0);
    chk32({nm, "_rdata1"}, m_rdata_o[63:32], 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic derr;
    logic [31:0] drd;
    int n, cyc;
`ifdef SB_DECERR_EN
    derr = 1'b1; drd = 32'hDEAD_BEEF;
`else
    derr = 1'b0; drd = 32'h0;
`endif
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst = 1'b1;

    // Word write then read
    wexp(12'h00F, 32'h4, 32'hCAFE_F00D);
    txn(0, 1, 2'b10, 0, 32'h10, 32'hCAFE_F00D, 2, 0, 32'h0);
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, 3, 0, 32'hCAFE_F00D);
    // Byte lanes and extension
    wexp(12'h008, 32'h4, 32'h5A5A_5A5A);
    txn(0, 1, 2'b00, 0, 32'h13, 32'h1234_565A, 2, 0, 32'h0);
    txn(0, 0, 2'b00, 0, 32'h13, 32'h0, 3, 0, 32'h0000_005A);
    wexp(12'h008, 32'h4, 32'h8080_8080);
    txn(1, 1, 2'b00, 0, 32'h13, 32'h80, 2, 0, 32'h0);
    txn(0, 0, 2'b00, 0, 32'h13, 32'h0, 3, 0, 32'hFFFF_FF80);
    txn(1, 0, 2'b00, 1, 32'h13, 32'h0, 3, 0, 32'h0000_0080);
    // Half lanes: word becomes 0xBEEF_F00D
    wexp(12'h00C, 32'h4, 32'hBEEF_BEEF);
    txn(1, 1, 2'b01, 0, 32'h12, 32'h1234_BEEF, 2, 0, 32'h0);
    txn(0, 0, 2'b01, 0, 32'h12, 32'h0, 3, 0, 32'hFFFF_BEEF);
    txn(1, 0, 2'b01, 1, 32'h10, 32'h0, 3, 0, 32'h0000_F00D);
    txn(0, 0, 2'b00, 1, 32'h11, 32'h0, 3, 0, 32'h0000_00F0);
    txn(1, 0, 2'b00, 0, 32'h11, 32'h0, 3, 0, 32'hFFFF_FFF0);
    txn(0, 0, 2'b11, 0, 32'h10, 32'h0, 3, 0, 32'hBEEF_F00D);
    // Slave select
    wexp(12'h0F0, 32'h0400_0002, 32'h1234_5678);
    txn(1, 1, 2'b10, 0, 32'h1000_0008, 32'h1234_5678, 2, 0, 32'h0);
    txn(1, 0, 2'b10, 0, 32'h1000_0008, 32'h0, 3, 0, 32'h1234_5678);
    wexp(12'hF00, 32'h0800_0003, 32'h0BAD_C0DE);
    txn(0, 1, 2'b10, 0, 32'h2000_000C, 32'h0BAD_C0DE, 2, 0, 32'h0);
    txn(0, 0, 2'b10, 0, 32'h2000_000C, 32'h0, 3, 0, 32'h0BAD_C0DE);
    // Misaligned
    txn(0, 0, 2'b01, 0, 32'h1, 32'h0, 2, 1, 32'h0);
    txn(1, 1, 2'b10, 0, 32'h2, 32'hFFFF_FFFF, 2, 1, 32'h0);
    // Unmapped slave index 3
    txn(1, 0, 2'b10, 0, 32'h3000_0000, 32'h0, 2, derr, drd);
    txn(0, 1, 2'b10, 0, 32'h3000_0004, 32'h1, 2, derr, drd);

    // Reset during ISSUE of a write: write-enable must vanish at once
    @(posedge clk); #1;
    m_we[0] = 1'b1; m_size[1:0] = 2'b10; m_addr[31:0] = 32'h10; m_wdata[31:0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk32("issue_rw", 32'(s_rw_o), 32'h00F);
    #1 rst = 1'b0;
    m_we[0] = 1'b0;
    #1 chk_all_zero("rst_issue");
    @(negedge clk) rst = 1'b1;

    // Reset during RESP of a read: no ack afterwards
    @(posedge clk); #1;
    m_re[0] = 1'b1; m_addr[31:0] = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    m_re[0] = 1'b0;
    #1 chk_all_zero("rst_resp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk32("rst_noack", 32'(m_ack_o), 32'h0);
    end
    rst = 1'b1;
    txn(0, 0, 2'b10, 0, 32'h10, 32'h0, 3, 0, 32'hBEEF_F00D);

    // Both masters requesting continuously: M0, M1, M0, M1
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aq.push_back(ack_t'{i % 2, 1'b0, 32'h0});
      if (i % 2 == 0) wexp(12'h00F, 32'h8, 32'h1111_1111);
      else            wexp(12'h00F, 32'h9, 32'h2222_2222);
    end
    @(posedge clk); #1;
    m_size = 4'b1010;
    m_addr = {32'h24, 32'h20};
    m_wdata = {32'h2222_2222, 32'h1111_1111};
    m_we = 2'b11;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 40) begin
      @(negedge clk);
      if (m_ack_o != '0) n++;
      cyc++;
    end
    m_we = 2'b00;
    chk32("rr_ack_count", 32'(n), 32'd4);
    txn(1, 0, 2'b10, 0, 32'h20, 32'h0, 3, 0, 32'h1111_1111);

    repeat (4) @(negedge clk);
    chk32("ack_queue_left", 32'(aq.size()), 32'h0);
    chk32("wr_queue_left", 32'(wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
